serial_link_physical_tx_mc: RTL and testbench
=============================================

// Module: serial_link_physical_tx_mc
// PURPOSE
// Multi-channel, runtime-configurable TX physical layer for the serial link. Serialises one
// NumChannels x (2*NumLanes) beat onto NumChannels x NumLanes wires per divided-clock period.
// Forwards one phase-shifted source-synchronous clock per channel.
// Adds runtime DDR/SDR mode, per-channel enable, a link-training pattern and a beat counter.
// Sits between the data-link layer and the pads.
// PARAMETERS
// NumChannels  1   independent channels, sharing one divider/handshake
// NumLanes     8   data wires per channel
// MaxClkDiv    32  maximum clk_div_i; CntW = $clog2(MaxClkDiv)+1
// CntBeatW     16  width of tx_beats_o
// PORTS
// clk_i          in   1                      system clock (sole clock)
// rst_ni         in   1                      asynchronous active-low reset
// clk_div_i      in   CntW                   divided period in clk_i cycles
// clk_shift_start_i in CntW                  counter value where forwarded clk toggles (1st edge)
// clk_shift_end_i   in CntW                  counter value where forwarded clk toggles (2nd edge)
// ddr_en_i       in   1                      1: DDR (2 halves/period), 0: SDR (low half only)
// chan_en_i      in   NumChannels            per-channel output enable
// train_en_i     in   1                      send training pattern instead of data
// data_i         in   NumChannels*2*NumLanes beat; channel c = data_i[c*2*NumLanes +: 2*NumLanes]
// valid_i        in   1                      beat valid
// ready_o        out  1                      beat accepted when valid_i & ready_o
// clk_o          out  NumChannels            forwarded clocks
// ddr_o          out  NumChannels*NumLanes   lane outputs
// tx_beats_o     out  CntBeatW               accepted-beat counter
// BEHAVIOUR
// - Reset: cnt_q=0, clk_o='1, ddr_o='0, beat_q='0, beat_vld_q=0, train_ph_q=0, tx_beats_o=0.
// - All outputs are registered. ready_o is the only combinational output.
// - Config inputs may change only while inactive; behaviour is undefined otherwise.
// - Effective divider: div = max(clk_div_i, 2). In DDR mode div must be even.
// - Shift values must be < div.
// - active = valid_i | train_en_i. While !active: cnt_q<=0, clk_o<='1, ddr_o<='0, beat_vld_q<=0.
// - Counter: while active, cnt_q <= (cnt_q==div-1) ? 0 : cnt_q+1.
// - ready_o = valid_i & ~train_en_i & (cnt_q==div-1).
// - Beat load, at the edge ending a cycle with active & cnt_q==div-1:
//   - beat_q <= (train_en_i ? pattern : data_i); beat_vld_q <= 1.
//   - DDR pattern: low half '0, high half '1 per channel.
//   - SDR pattern: all lanes = train_ph_q; train_ph_q toggles on each load.
// - tx_beats_o += 1 (wrapping) on each valid_i & ready_o. No increment for training beats.
// - Data out, channel c, evaluated at each edge while active:
//   - cnt_q==0: ddr_o <= beat_vld_q ? low half of beat_q : '0.
//   - DDR and cnt_q==div/2: ddr_o <= beat_vld_q ? high half of beat_q : '0.
//   - Otherwise ddr_o holds.
// - Latency: beat accepted in cycle T -> low half on ddr_o from T+2 -> high half from T+2+div/2.
// - The first period after going active outputs '0; the pipeline is priming.
// - Forwarded clock: while active, clk_o[c] toggles at an edge where
//   cnt_q==clk_shift_start_i or cnt_q==clk_shift_end_i.
//   - If start==end, toggle once (SDR-style, period 2*div).
// - Channel c with chan_en_i[c]=0: clk_o[c] held 1, ddr_o lanes held 0.
//   - Its counter/handshake is unaffected.
// - valid_i dropping mid-period (train off): full idle on next edge; the in-flight beat is
//   discarded; ready_o is never asserted in that period.
// - Asynchronous reset mid-operation: immediate return to reset values, no partial beat.
// TESTING
// - T1 SDR, div=4, start=0, end=2, 1 ch, NumLanes=8:
//   - beats 0x00A5, 0x005A back-to-back.
//   - ready_o every 4th cycle; ddr_o = A5 then 5A, 4 cycles each.
//   - clk_o period 4; tx_beats_o=2.
// - T2 DDR, div=4, start=1, end=3, beat 0x3CC3:
//   - ddr_o = C3 (cycles T+2..T+3), then 3C (T+4..T+5).
//   - clk_o toggles at cnt 1 and 3.
// - T3 train_en_i=1, valid_i=0, DDR, div=2:
//   - lanes alternate 00/FF each cycle after priming; ready_o stays 0; tx_beats_o stays 0.
// - T4 2 channels, chan_en_i=2'b01, beat {0xFFFF,0x1234}:
//   - channel 1 clk_o=1, ddr_o=0; channel 0 sends 34 then 12 (DDR).
// - T5 valid_i dropped at cnt=1, div=8:
//   - next edge clk_o=1, ddr_o=0, cnt=0, no ready_o pulse.
//   - rst_ni pulse mid-beat -> all outputs at reset values immediately.
// - T6 clk_div_i=1, DDR:
//   - behaves as div=2.
//   - tx_beats_o wraps 0xFFFF->0 after 65536 beats (counter forced near wrap).

Source files
------------

// File: rtl/serial_link_physical_tx_mc.sv
// Multi-channel TX physical layer: serialises a 2*NumLanes beat per channel onto NumLanes wires
// per divided-clock period (DDR or SDR) and forwards a phase-shifted clock per channel.
module serial_link_physical_tx_mc #(
    parameter int unsigned NumChannels = 1,
    parameter int unsigned NumLanes    = 8,
    parameter int unsigned MaxClkDiv   = 32,
    parameter int unsigned CntBeatW    = 16,
    localparam int unsigned CntW       = $clog2(MaxClkDiv) + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [CntW-1:0]                 clk_div_i,
    input  logic [CntW-1:0]                 clk_shift_start_i,
    input  logic [CntW-1:0]                 clk_shift_end_i,
    input  logic                            ddr_en_i,
    input  logic [NumChannels-1:0]          chan_en_i,
    input  logic                            train_en_i,
    input  logic [NumChannels*2*NumLanes-1:0] data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [NumChannels-1:0]          clk_o,
    output logic [NumChannels*NumLanes-1:0] ddr_o,
    output logic [CntBeatW-1:0]             tx_beats_o
);

    localparam int unsigned BeatW = 2 * NumLanes;

    logic [CntW-1:0]                 r_cnt;
    logic [NumChannels-1:0]          r_clk;
    logic [NumChannels*NumLanes-1:0] r_ddr;
    logic [NumChannels*BeatW-1:0]    r_beat;
    logic                            r_beat_vld;
    logic                            r_train_ph;
    logic [CntBeatW-1:0]             r_tx_beats;

    logic [CntW-1:0]                 w_div;
    logic [CntW-1:0]                 w_half;
    logic                            w_last;
    logic                            w_active;
    logic                            w_toggle;
    logic                            w_accept;
    logic [NumChannels*BeatW-1:0]    w_pattern;
    logic [NumChannels*BeatW-1:0]    w_beat_d;
    logic [NumChannels*NumLanes-1:0] w_ddr_d;
    logic [NumChannels-1:0]          w_clk_d;

    // Handshake: a beat transfers on a cycle where valid_i && ready_o; ready_o only rises in the
    // last counter slot of a period, and never while the training pattern owns the link.
    assign w_div    = (clk_div_i < CntW'(2)) ? CntW'(2) : clk_div_i;
    assign w_half   = w_div >> 1;
    assign w_last   = (r_cnt == w_div - CntW'(1));
    assign w_active = valid_i | train_en_i;
    assign w_toggle = (r_cnt == clk_shift_start_i) || (r_cnt == clk_shift_end_i);
    assign ready_o  = valid_i & ~train_en_i & w_last;
    assign w_accept = valid_i & ready_o;

    always_comb begin
        w_pattern = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (ddr_en_i) begin
                w_pattern[c*BeatW+NumLanes +: NumLanes] = '1;
            end else begin
                w_pattern[c*BeatW +: BeatW] = {BeatW{r_train_ph}};
            end
        end
    end

    assign w_beat_d = train_en_i ? w_pattern : data_i;

    // Disabled channels park their pins; the shared counter keeps running regardless.
    always_comb begin
        w_ddr_d = r_ddr;
        w_clk_d = r_clk;
        for (int c = 0; c < NumChannels; c++) begin
            if (!chan_en_i[c]) begin
                w_ddr_d[c*NumLanes +: NumLanes] = '0;
                w_clk_d[c]                      = 1'b1;
            end else begin
                if (r_cnt == '0) begin
                    w_ddr_d[c*NumLanes +: NumLanes] =
                        r_beat_vld ? r_beat[c*BeatW +: NumLanes] : '0;
                end else if (ddr_en_i && (r_cnt == w_half)) begin
                    w_ddr_d[c*NumLanes +: NumLanes] =
                        r_beat_vld ? r_beat[c*BeatW+NumLanes +: NumLanes] : '0;
                end
                if (w_toggle) begin
                    w_clk_d[c] = ~r_clk[c];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_clk      <= '1;
            r_ddr      <= '0;
            r_beat     <= '0;
            r_beat_vld <= 1'b0;
            r_train_ph <= 1'b0;
        end else if (!w_active) begin
            r_cnt      <= '0;
            r_clk      <= '1;
            r_ddr      <= '0;
            r_beat_vld <= 1'b0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + CntW'(1);
            r_clk <= w_clk_d;
            r_ddr <= w_ddr_d;
            if (w_last) begin
                r_beat     <= w_beat_d;
                r_beat_vld <= 1'b1;
                if (train_en_i && !ddr_en_i) begin
                    r_train_ph <= ~r_train_ph;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_beats <= '0;
        end else if (w_accept) begin
            r_tx_beats <= r_tx_beats + CntBeatW'(1);
        end
    end

    assign clk_o      = r_clk;
    assign ddr_o      = r_ddr;
    assign tx_beats_o = r_tx_beats;

endmodule

// File: tb/tb_serial_link_physical_tx_mc.sv
// Directed bench for serial_link_physical_tx_mc: two channels, 8 lanes, an 8-bit beat counter
// so that the counter wrap is reachable in a short run.
module tb_serial_link_physical_tx_mc;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [5:0]  clk_div_i;
    logic [5:0]  clk_shift_start_i;
    logic [5:0]  clk_shift_end_i;
    logic        ddr_en_i;
    logic [1:0]  chan_en_i;
    logic        train_en_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  clk_o;
    logic [15:0] ddr_o;
    logic [7:0]  tx_beats_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    serial_link_physical_tx_mc #(
        .NumChannels(2),
        .NumLanes   (8),
        .MaxClkDiv  (32),
        .CntBeatW   (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clk_div_i        (clk_div_i),
        .clk_shift_start_i(clk_shift_start_i),
        .clk_shift_end_i  (clk_shift_end_i),
        .ddr_en_i         (ddr_en_i),
        .chan_en_i        (chan_en_i),
        .train_en_i       (train_en_i),
        .data_i           (data_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .clk_o            (clk_o),
        .ddr_o            (ddr_o),
        .tx_beats_o       (tx_beats_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic step(input logic v, input logic t, input logic [31:0] d);
        @(posedge clk_i);
        #1;
        valid_i    = v;
        train_en_i = t;
        data_i     = d;
        #1;
    endtask

    task automatic set_cfg(input logic [5:0] div, input logic [5:0] s, input logic [5:0] e,
                           input logic ddr, input logic [1:0] chen);
        clk_div_i         = div;
        clk_shift_start_i = s;
        clk_shift_end_i   = e;
        ddr_en_i          = ddr;
        chan_en_i         = chen;
    endtask

    task automatic test_reset();
        set_cfg(6'd4, 6'd0, 6'd2, 1'b0, 2'b01);
        valid_i = 1'b1;
        #1;
        tests_run++;
        if (clk_o !== 2'b11) begin
            tests_failed++; $display("FAIL rst_clk got %b exp 11", clk_o);
        end
        tests_run++;
        if (ddr_o !== 16'h0) begin
            tests_failed++; $display("FAIL rst_ddr got %h exp 0000", ddr_o);
        end
        tests_run++;
        if (tx_beats_o !== 8'h0) begin
            tests_failed++; $display("FAIL rst_tx got %h exp 00", tx_beats_o);
        end
        tests_run++;
        if (ready_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_ready got %b exp 0", ready_o);
        end
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (clk_o !== 2'b11 || ddr_o !== 16'h0) begin
            tests_failed++; $display("FAIL rst_idle got clk %b ddr %h exp 11 0000", clk_o, ddr_o);
        end
    endtask

    task automatic test_sdr();
        logic        v   [15] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,0};
        logic        t   [15] = '{0,0,0,0,0,0,0,0,1,1,1,1,1,0,0};
        logic [7:0]  d   [15] = '{8'hA5,8'hA5,8'hA5,8'hA5,8'h5A,8'h5A,8'h5A,8'h5A,
                                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        logic        rdy [15] = '{0,0,0,1,0,0,0,1,0,0,0,0,0,0,0};
        logic [1:0]  eclk[15] = '{3,2,2,3,3,2,2,3,3,2,2,3,3,2,3};
        logic [7:0]  eddr[15] = '{8'h00,8'h00,8'h00,8'h00,8'h00,8'hA5,8'hA5,8'hA5,
                                  8'hA5,8'h5A,8'h5A,8'h5A,8'h5A,8'h00,8'h00};
        set_cfg(6'd4, 6'd0, 6'd2, 1'b0, 2'b01);
        for (int c = 0; c < 15; c++) begin
            step(v[c], t[c], {24'h0, d[c]});
            tests_run++;
            if (ready_o !== rdy[c]) begin
                tests_failed++; $display("FAIL sdr_ready c=%0d got %b exp %b", c, ready_o, rdy[c]);
            end
            tests_run++;
            if (clk_o !== eclk[c]) begin
                tests_failed++; $display("FAIL sdr_clk c=%0d got %b exp %b", c, clk_o, eclk[c]);
            end
            tests_run++;
            if (ddr_o !== {8'h00, eddr[c]}) begin
                tests_failed++; $display("FAIL sdr_ddr c=%0d got %h exp %h", c, ddr_o, {8'h00, eddr[c]});
            end
        end
        tests_run++;
        if (tx_beats_o !== 8'd2) begin
            tests_failed++; $display("FAIL sdr_tx got %0d exp 2", tx_beats_o);
        end
    endtask

    task automatic test_ddr();
        logic        v   [11] = '{1,1,1,1,1,1,1,1,1,0,0};
        logic [15:0] d   [11] = '{16'h3CC3,16'h3CC3,16'h3CC3,16'h3CC3,16'h0,16'h0,16'h0,
                                  16'h0,16'h0,16'h0,16'h0};
        logic        rdy [11] = '{0,0,0,1,0,0,0,1,0,0,0};
        logic [1:0]  eclk[11] = '{3,3,2,2,3,3,2,2,3,3,3};
        logic [7:0]  eddr[11] = '{8'h00,8'h00,8'h00,8'h00,8'h00,8'hC3,8'hC3,8'h3C,8'h3C,
                                  8'h00,8'h00};
        set_cfg(6'd4, 6'd1, 6'd3, 1'b1, 2'b01);
        for (int c = 0; c < 11; c++) begin
            step(v[c], 1'b0, {16'h0, d[c]});
            tests_run++;
            if (ready_o !== rdy[c]) begin
                tests_failed++; $display("FAIL ddr_ready c=%0d got %b exp %b", c, ready_o, rdy[c]);
            end
            tests_run++;
            if (clk_o !== eclk[c]) begin
                tests_failed++; $display("FAIL ddr_clk c=%0d got %b exp %b", c, clk_o, eclk[c]);
            end
            tests_run++;
            if (ddr_o !== {8'h00, eddr[c]}) begin
                tests_failed++; $display("FAIL ddr_ddr c=%0d got %h exp %h", c, ddr_o, {8'h00, eddr[c]});
            end
        end
        tests_run++;
        if (tx_beats_o !== 8'd4) begin
            tests_failed++; $display("FAIL ddr_tx got %0d exp 4", tx_beats_o);
        end
    endtask

    task automatic test_training();
        logic        t   [10] = '{1,1,1,1,1,1,1,1,0,0};
        logic [1:0]  eclk[10] = '{3,0,3,0,3,0,3,0,3,3};
        logic [15:0] eddr[10] = '{16'h0,16'h0,16'h0,16'h0,16'hFFFF,16'h0,16'hFFFF,16'h0,
                                  16'hFFFF,16'h0};
        set_cfg(6'd2, 6'd0, 6'd1, 1'b1, 2'b11);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, t[c], 32'hDEADBEEF);
            tests_run++;
            if (ready_o !== 1'b0) begin
                tests_failed++; $display("FAIL train_ready c=%0d got %b exp 0", c, ready_o);
            end
            tests_run++;
            if (clk_o !== eclk[c]) begin
                tests_failed++; $display("FAIL train_clk c=%0d got %b exp %b", c, clk_o, eclk[c]);
            end
            tests_run++;
            if (ddr_o !== eddr[c]) begin
                tests_failed++; $display("FAIL train_ddr c=%0d got %h exp %h", c, ddr_o, eddr[c]);
            end
        end
        tests_run++;
        if (tx_beats_o !== 8'd4) begin
            tests_failed++; $display("FAIL train_tx got %0d exp 4", tx_beats_o);
        end
    endtask

    task automatic test_chan_enable();
        logic        v   [6] = '{1,1,1,1,0,0};
        logic [31:0] d   [6] = '{32'hFFFF1234,32'hFFFF1234,32'hFFFF0000,32'hFFFF0000,32'h0,32'h0};
        logic        rdy [6] = '{0,1,0,1,0,0};
        logic [1:0]  eclk[6] = '{3,2,2,3,3,3};
        logic [15:0] eddr[6] = '{16'h0,16'h0,16'h0,16'h0034,16'h0012,16'h0};
        set_cfg(6'd2, 6'd0, 6'd0, 1'b1, 2'b01);
        for (int c = 0; c < 6; c++) begin
            step(v[c], 1'b0, d[c]);
            tests_run++;
            if (ready_o !== rdy[c]) begin
                tests_failed++; $display("FAIL chen_ready c=%0d got %b exp %b", c, ready_o, rdy[c]);
            end
            tests_run++;
            if (clk_o !== eclk[c]) begin
                tests_failed++; $display("FAIL chen_clk c=%0d got %b exp %b", c, clk_o, eclk[c]);
            end
            tests_run++;
            if (ddr_o !== eddr[c]) begin
                tests_failed++; $display("FAIL chen_ddr c=%0d got %h exp %h", c, ddr_o, eddr[c]);
            end
        end
        tests_run++;
        if (tx_beats_o !== 8'd6) begin
            tests_failed++; $display("FAIL chen_tx got %0d exp 6", tx_beats_o);
        end
    endtask

    task automatic test_drop_and_reset();
        set_cfg(6'd8, 6'd0, 6'd4, 1'b0, 2'b01);
        step(1'b1, 1'b0, 32'hAA);
        tests_run++;
        if (ready_o !== 1'b0 || clk_o !== 2'b11) begin
            tests_failed++; $display("FAIL drop_c0 got rdy %b clk %b exp 0 11", ready_o, clk_o);
        end
        step(1'b0, 1'b0, 32'hAA);
        tests_run++;
        if (clk_o !== 2'b10) begin
            tests_failed++; $display("FAIL drop_c1_clk got %b exp 10", clk_o);
        end
        step(1'b0, 1'b0, 32'h0);
        tests_run++;
        if (clk_o !== 2'b11 || ddr_o !== 16'h0) begin
            tests_failed++; $display("FAIL drop_idle got clk %b ddr %h exp 11 0000", clk_o, ddr_o);
        end
        // A counter restarted from 0 gives the first ready in the 8th active cycle.
        for (int c = 3; c <= 12; c++) begin
            step(1'b1, 1'b0, 32'hAA);
            tests_run++;
            if (ready_o !== (c == 10)) begin
                tests_failed++; $display("FAIL drop_ready c=%0d got %b exp %b", c, ready_o, (c == 10));
            end
            if (c == 4) begin
                tests_run++;
                if (clk_o !== 2'b10) begin
                    tests_failed++; $display("FAIL drop_clk c=4 got %b exp 10", clk_o);
                end
            end
            if (c == 8) begin
                tests_run++;
                if (clk_o !== 2'b11) begin
                    tests_failed++; $display("FAIL drop_clk c=8 got %b exp 11", clk_o);
                end
            end
        end
        tests_run++;
        if (ddr_o !== 16'h00AA || clk_o !== 2'b10 || tx_beats_o !== 8'd7) begin
            tests_failed++;
            $display("FAIL drop_beat got ddr %h clk %b tx %0d exp 00aa 10 7", ddr_o, clk_o, tx_beats_o);
        end
        rst_ni = 1'b0;
        #2;
        tests_run++;
        if (clk_o !== 2'b11 || ddr_o !== 16'h0 || tx_beats_o !== 8'd0 || ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_rst got clk %b ddr %h tx %0d rdy %b exp 11 0000 0 0",
                     clk_o, ddr_o, tx_beats_o, ready_o);
        end
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  k;
        logic [7:0]  e_tx;
        logic [1:0]  e_clk;
        logic [15:0] e_ddr;
        int          acc;
        set_cfg(6'd1, 6'd0, 6'd1, 1'b1, 2'b01);
        for (int c = 0; c < 516; c++) begin
            k = 8'(c / 2);
            step(c < 514, 1'b0, {16'h0, k, ~k});
            acc   = (c < 514 ? c : 514) / 2;
            e_tx  = 8'(acc);
            e_clk = (c > 514) ? 2'b11 : {1'b1, (c % 2) == 0};
            if (c < 3 || c > 514) e_ddr = 16'h0;
            else if (c % 2 == 1)  e_ddr = {8'h00, ~8'((c - 3) / 2)};
            else                  e_ddr = {8'h00, 8'((c - 4) / 2)};
            tests_run++;
            if (ready_o !== (c < 514 && (c % 2) == 1)) begin
                tests_failed++; $display("FAIL b2b_ready c=%0d got %b", c, ready_o);
            end
            tests_run++;
            if (tx_beats_o !== e_tx) begin
                tests_failed++; $display("FAIL b2b_tx c=%0d got %0d exp %0d", c, tx_beats_o, e_tx);
            end
            tests_run++;
            if (clk_o !== e_clk) begin
                tests_failed++; $display("FAIL b2b_clk c=%0d got %b exp %b", c, clk_o, e_clk);
            end
            tests_run++;
            if (ddr_o !== e_ddr) begin
                tests_failed++; $display("FAIL b2b_ddr c=%0d got %h exp %h", c, ddr_o, e_ddr);
            end
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        valid_i    = 1'b0;
        train_en_i = 1'b0;
        data_i     = 32'h0;
        set_cfg(6'd4, 6'd0, 6'd2, 1'b0, 2'b01);
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_sdr();
        test_ddr();
        test_training();
        test_chan_enable();
        test_drop_and_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
